ps2_key_tracker: RTL
====================

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 Parameter NUM_KEYS, default 33, number of tracked keys (1..33); scan-table entries with index >= NUM_KEYS are treated as unmapped.
REQ-002 Parameter LOCK_SPLIT, default 31, first key index of lock group B; indices below it form group A (1..NUM_KEYS-1).
REQ-003 Parameter TIMEOUT_CYCLES, default 50000, number of idle clocks before a partial frame is abandoned.
REQ-004 CLOCK_50  input  1  system clock; all logic is on its rising edge.
REQ-005 Resetn  input  1  reset, asynchronous assert, active-low.
REQ-006 PS2_CLK  input  1  raw PS/2 clock from the keyboard (receive only).
REQ-007 PS2_DAT  input  1  raw PS/2 data from the keyboard.
REQ-008 code  output  8  last accepted scan byte, excluding E0/F0 prefixes.
REQ-009 code_ext  output  1  the last code was preceded by E0.
REQ-010 code_break  output  1  the last code was preceded by F0.
REQ-011 code_valid  output  1  one-cycle pulse when code, code_ext and code_break update.
REQ-012 frame_err  output  1  one-cycle pulse on a rejected frame or a timeout.
REQ-013 key_down  output  NUM_KEYS  live pressed-state bitmap.
REQ-014 key_lock  output  NUM_KEYS  toggle-latched bitmap; at most one bit set per group.

Function
REQ-015 PS2_CLK and PS2_DAT shall pass through 2-flop synchronisers; a falling edge is detected from the synchronised clock, giving 3 cycles of latency from the pin.
REQ-016 On each falling edge the frame shifter shall capture one bit, LSB first, and a 4-bit counter shall count bits 0..10.
REQ-017 On bit 10 the frame shall be checked: start=0, stop=1, odd parity over 8 data bits plus the parity bit.
REQ-018 A valid frame shall pass its byte to the decoder on the next cycle.
REQ-019 An invalid frame shall raise frame_err for 1 cycle, discard the byte, and leave the decoder state unchanged.
REQ-020 If no falling edge occurs for TIMEOUT_CYCLES while the bit counter is nonzero, the counter shall clear and frame_err shall pulse.
REQ-021 Decoder FSM states: IDLE, EXT, BRK, EXT_BRK.
REQ-022 FSM transitions on bytes: E0 moves IDLE to EXT; F0 moves IDLE to BRK and EXT to EXT_BRK.
REQ-023 Any other byte shall emit code_valid with the current flags and return the FSM to IDLE.
REQ-024 A repeated prefix shall be absorbed with no transition.
REQ-025 Lookup: non-extended codes map via the fixed 33-entry table in the package (A..Z, F4, F3, Space, Enter, Backspace, LShift=31, LCtrl=32).
REQ-026 Extended codes and unmapped codes shall update code and pulse code_valid without touching either bitmap.
REQ-027 On a make of key k: key_down[k] shall be set; if key_down[k] was already 1 (typematic repeat), key_lock shall not change.
REQ-028 On a break of key k, key_down[k] shall clear.
REQ-029 On a fresh make of k in group G: if G's lock is empty, set key_lock[k].
REQ-030 If key_lock[k] is already set, clear it.
REQ-031 If a different key of G is locked, hold G unchanged.
REQ-032 Groups A and B shall update independently.
REQ-033 Bitmaps shall update in the same cycle as code_valid.

Reset
REQ-034 While Resetn=0, all outputs, both bitmaps, the shifter, the counters and the FSM shall read 0 / IDLE immediately.
REQ-035 Reset asserted mid-frame shall discard the frame; after release the first falling edge is treated as bit 0.

Configuration
REQ-036 PS2_PARITY_CHECK_EN defined: parity is checked per REQ-017.
REQ-037 PS2_PARITY_CHECK_EN undefined: parity is ignored, and only start and stop bits can cause frame_err.

Structure
REQ-038 Package ps2_key_pkg shall hold the scan-code constants, the E0/F0 prefix constants, the key-index constants, the FSM state typedef and the lookup function.
REQ-039 Sub-module ps2_rx_frame shall contain the synchroniser, edge detect, shifter, checker and timeout, and shall output a byte, a byte_valid pulse and frame_err.

Verification
REQ-040 Frame 1C with good parity -> code=1C, code_valid pulse, key_down[0]=1, key_lock[0]=1.
REQ-041 Sequence 1C, F0 1C, 1C -> key_lock[0] toggles 1 then 0; key_down[0] ends at 1.
REQ-042 Sequence 1C 1C 1C (typematic) -> key_lock[0] stays 1 and three code_valid pulses occur.
REQ-043 Sequence 1C then 32 (group A) -> key_lock[0]=1, key_lock[1]=0; then 12 -> key_lock[31]=1.
REQ-044 Frame with flipped parity -> frame_err pulse and no code_valid; the same with the macro undefined -> code accepted.
REQ-045 Six bits then silence for TIMEOUT_CYCLES -> frame_err pulse, then a clean 1C frame is decoded correctly.

Source files
------------

// File: rtl/ps2_key_pkg.sv
// Shared constants for the PS/2 key tracker.
// Holds the scan codes, the E0/F0 prefix bytes, the key indices, the decoder
// state type and the scan-code to key-index lookup.
package ps2_key_pkg;

  localparam int unsigned IDX_W = 6;

  localparam logic [7:0] SC_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] SC_PREFIX_BRK = 8'hF0;

  localparam logic [7:0] SC_A = 8'h1C, SC_B = 8'h32, SC_C = 8'h21, SC_D = 8'h23;
  localparam logic [7:0] SC_E = 8'h24, SC_F = 8'h2B, SC_G = 8'h34, SC_H = 8'h33;
  localparam logic [7:0] SC_I = 8'h43, SC_J = 8'h3B, SC_K = 8'h42, SC_L = 8'h4B;
  localparam logic [7:0] SC_M = 8'h3A, SC_N = 8'h31, SC_O = 8'h44, SC_P = 8'h4D;
  localparam logic [7:0] SC_Q = 8'h15, SC_R = 8'h2D, SC_S = 8'h1B, SC_T = 8'h2C;
  localparam logic [7:0] SC_U = 8'h3C, SC_V = 8'h2A, SC_W = 8'h1D, SC_X = 8'h22;
  localparam logic [7:0] SC_Y = 8'h35, SC_Z = 8'h1A;
  localparam logic [7:0] SC_F4 = 8'h0C, SC_F3 = 8'h04, SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A, SC_BKSP = 8'h66;
  localparam logic [7:0] SC_LSHIFT = 8'h12, SC_LCTRL = 8'h14;

  localparam logic [IDX_W-1:0] KEY_A = 6'd0,  KEY_B = 6'd1,  KEY_C = 6'd2,  KEY_D = 6'd3;
  localparam logic [IDX_W-1:0] KEY_E = 6'd4,  KEY_F = 6'd5,  KEY_G = 6'd6,  KEY_H = 6'd7;
  localparam logic [IDX_W-1:0] KEY_I = 6'd8,  KEY_J = 6'd9,  KEY_K = 6'd10, KEY_L = 6'd11;
  localparam logic [IDX_W-1:0] KEY_M = 6'd12, KEY_N = 6'd13, KEY_O = 6'd14, KEY_P = 6'd15;
  localparam logic [IDX_W-1:0] KEY_Q = 6'd16, KEY_R = 6'd17, KEY_S = 6'd18, KEY_T = 6'd19;
  localparam logic [IDX_W-1:0] KEY_U = 6'd20, KEY_V = 6'd21, KEY_W = 6'd22, KEY_X = 6'd23;
  localparam logic [IDX_W-1:0] KEY_Y = 6'd24, KEY_Z = 6'd25;
  localparam logic [IDX_W-1:0] KEY_F4 = 6'd26, KEY_F3 = 6'd27, KEY_SPACE = 6'd28;
  localparam logic [IDX_W-1:0] KEY_ENTER = 6'd29, KEY_BKSP = 6'd30;
  localparam logic [IDX_W-1:0] KEY_LSHIFT = 6'd31, KEY_LCTRL = 6'd32;

  // Decoder states
  typedef logic [1:0] dec_state_t;
  localparam dec_state_t ST_IDLE    = 2'd0;
  localparam dec_state_t ST_EXT     = 2'd1;
  localparam dec_state_t ST_BRK     = 2'd2;
  localparam dec_state_t ST_EXT_BRK = 2'd3;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } key_lookup_t;

  // Non-extended scan code to key index; hit=0 for codes outside the table
  function automatic key_lookup_t key_lookup(input logic [7:0] sc);
    key_lookup_t r;
    r.hit = 1'b1;
    r.idx = '0;
    case (sc)
      SC_A: r.idx = KEY_A;  SC_B: r.idx = KEY_B;  SC_C: r.idx = KEY_C;  SC_D: r.idx = KEY_D;
      SC_E: r.idx = KEY_E;  SC_F: r.idx = KEY_F;  SC_G: r.idx = KEY_G;  SC_H: r.idx = KEY_H;
      SC_I: r.idx = KEY_I;  SC_J: r.idx = KEY_J;  SC_K: r.idx = KEY_K;  SC_L: r.idx = KEY_L;
      SC_M: r.idx = KEY_M;  SC_N: r.idx = KEY_N;  SC_O: r.idx = KEY_O;  SC_P: r.idx = KEY_P;
      SC_Q: r.idx = KEY_Q;  SC_R: r.idx = KEY_R;  SC_S: r.idx = KEY_S;  SC_T: r.idx = KEY_T;
      SC_U: r.idx = KEY_U;  SC_V: r.idx = KEY_V;  SC_W: r.idx = KEY_W;  SC_X: r.idx = KEY_X;
      SC_Y: r.idx = KEY_Y;  SC_Z: r.idx = KEY_Z;
      SC_F4:     r.idx = KEY_F4;
      SC_F3:     r.idx = KEY_F3;
      SC_SPACE:  r.idx = KEY_SPACE;
      SC_ENTER:  r.idx = KEY_ENTER;
      SC_BKSP:   r.idx = KEY_BKSP;
      SC_LSHIFT: r.idx = KEY_LSHIFT;
      SC_LCTRL:  r.idx = KEY_LCTRL;
      default:   r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// Output bundle of the key tracker.
// code/code_ext/code_break/code_valid : decoded byte event
// frame_err                          : rejected frame or timeout pulse
// key_down/key_lock                  : pressed and lock-toggle bitmaps
interface ps2_key_tracker_if #(
  parameter int unsigned NUM_KEYS = 33
);
  logic [7:0]          code;
  logic                code_ext;
  logic                code_break;
  logic                code_valid;
  logic                frame_err;
  logic [NUM_KEYS-1:0] key_down;
  logic [NUM_KEYS-1:0] key_lock;

  modport master (
    output code, code_ext, code_break, code_valid, frame_err, key_down, key_lock
  );

  modport slave (
    input code, code_ext, code_break, code_valid, frame_err, key_down, key_lock
  );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 receive framer: synchronises the raw pins, detects falling clock edges,
// shifts in an 11-bit frame LSB first, checks it and abandons stalled frames.
// Ports: clk, rst_n        - system clock, async active-low reset
//        ps2_clk_i/dat_i   - raw PS/2 pins
//        byte_o            - last good data byte
//        byte_valid_o      - one-cycle pulse, byte_o updated
//        frame_err_o       - one-cycle pulse on bad frame or timeout
// Macro PS2_PARITY_CHECK_EN enables the odd-parity check; start/stop are always checked.
module ps2_rx_frame #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       clk_sync_q;
  logic [1:0]       dat_sync_q;
  logic             clk_prev_q;
  logic             fall_c;
  logic [10:0]      shift_q, shift_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0] idle_q, idle_d;
  logic [7:0]       byte_q, byte_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;
  logic [10:0]      frame_c;
  logic             frame_ok_c;

  // Two-flop synchronisers plus one delay stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= '0;
      dat_sync_q <= '0;
      clk_prev_q <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  assign fall_c = clk_prev_q & ~clk_sync_q[1];

  // Frame as it stands after the current bit is shifted in; bit 0 is start
  always_comb begin
    frame_c    = {dat_sync_q[1], shift_q[10:1]};
    frame_ok_c = ~frame_c[0] & frame_c[10];
`ifdef PS2_PARITY_CHECK_EN
    frame_ok_c = frame_ok_c & (^frame_c[9:1]);
`endif
  end

  // Shifter, bit counter, frame check and idle timeout
  always_comb begin
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    idle_d       = idle_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (fall_c) begin
      idle_d  = '0;
      shift_d = frame_c;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = '0;
        if (frame_ok_c) begin
          byte_d       = frame_c[8:1];
          byte_valid_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (idle_q == TMO_LAST) begin
        idle_d      = '0;
        bit_cnt_d   = '0;
        frame_err_d = 1'b1;
      end else begin
        idle_d = idle_q + TMO_W'(1);
      end
    end else begin
      idle_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      idle_q       <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      idle_q       <= idle_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = byte_valid_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard tracker: decodes E0/F0 prefixed scan codes and maintains a
// live pressed-key bitmap and a per-group toggle-lock bitmap.
// Ports: CLOCK_50, Resetn   - system clock, async active-low reset
//        PS2_CLK, PS2_DAT   - raw PS/2 pins
//        evt (master)       - code/code_ext/code_break/code_valid, frame_err,
//                             key_down, key_lock
// Macro PS2_PARITY_CHECK_EN enables frame parity checking in ps2_rx_frame.
module ps2_key_tracker
  import ps2_key_pkg::*;
#(
  parameter int unsigned NUM_KEYS       = 33,
  parameter int unsigned LOCK_SPLIT     = 31,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                CLOCK_50,
  input  logic                Resetn,
  input  logic                PS2_CLK,
  input  logic                PS2_DAT,
  ps2_key_tracker_if.master   evt
);

  // Keys at or above LOCK_SPLIT form lock group B
  function automatic logic [NUM_KEYS-1:0] grp_b_mask_f();
    logic [NUM_KEYS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (i >= LOCK_SPLIT) m = m | (NUM_KEYS'(1) << i);
    end
    return m;
  endfunction

  localparam logic [NUM_KEYS-1:0] GRP_B_MASK = grp_b_mask_f();

  logic [7:0]          rx_byte;
  logic                rx_valid;
  logic                rx_err;

  dec_state_t          state_q, state_d;
  logic [7:0]          code_q, code_d;
  logic                ext_q, ext_d;
  logic                brk_q, brk_d;
  logic                valid_q, valid_d;
  logic [NUM_KEYS-1:0] down_q, down_d;
  logic [NUM_KEYS-1:0] lock_q, lock_d;

  key_lookup_t         lk_c;
  logic [NUM_KEYS-1:0] key_oh_c;
  logic [NUM_KEYS-1:0] grp_mask_c;
  logic                is_ext_c;
  logic                is_brk_c;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk          (CLOCK_50),
    .rst_n        (Resetn),
    .ps2_clk_i    (PS2_CLK),
    .ps2_dat_i    (PS2_DAT),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_err)
  );

  // Decoder next state plus event and bitmap updates
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    ext_d      = ext_q;
    brk_d      = brk_q;
    valid_d    = 1'b0;
    down_d     = down_q;
    lock_d     = lock_q;
    lk_c       = key_lookup(rx_byte);
    key_oh_c   = '0;
    is_ext_c   = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    is_brk_c   = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
    if (lk_c.hit && (32'(lk_c.idx) < NUM_KEYS)) key_oh_c = NUM_KEYS'(1) << lk_c.idx;
    grp_mask_c = (|(key_oh_c & GRP_B_MASK)) ? GRP_B_MASK : ~GRP_B_MASK;

    if (rx_valid) begin
      if (rx_byte == SC_PREFIX_EXT) begin
        // E0 only opens an extended sequence from IDLE; otherwise absorbed
        if (state_q == ST_IDLE) state_d = ST_EXT;
      end else if (rx_byte == SC_PREFIX_BRK) begin
        case (state_q)
          ST_IDLE: state_d = ST_BRK;
          ST_EXT:  state_d = ST_EXT_BRK;
          default: state_d = state_q;
        endcase
      end else begin
        code_d  = rx_byte;
        ext_d   = is_ext_c;
        brk_d   = is_brk_c;
        valid_d = 1'b1;
        state_d = ST_IDLE;
        if (!is_ext_c && (|key_oh_c)) begin
          if (is_brk_c) begin
            down_d = down_q & ~key_oh_c;
          end else if (!(|(down_q & key_oh_c))) begin
            // Fresh make: toggle own lock, claim an empty group, else hold
            down_d = down_q | key_oh_c;
            if (|(lock_q & key_oh_c))         lock_d = lock_q & ~key_oh_c;
            else if (!(|(lock_q & grp_mask_c))) lock_d = lock_q | key_oh_c;
          end
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      valid_q <= 1'b0;
      down_q  <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      valid_q <= valid_d;
      down_q  <= down_d;
      lock_q  <= lock_d;
    end
  end

  assign evt.code       = code_q;
  assign evt.code_ext   = ext_q;
  assign evt.code_break = brk_q;
  assign evt.code_valid = valid_q;
  assign evt.frame_err  = rx_err;
  assign evt.key_down   = down_q;
  assign evt.key_lock   = lock_q;

endmodule
